// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types, default timing constants and the clear/home
//                decode for the HD44780 LCD bus arbiter.
//  Contents    : lcd_state_e FSM encoding, default cycle counts, RS
//                encodings, is_long_cmd() helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } lcd_state_e;

    localparam int c_SETUP_CYC     = 2;
    localparam int c_PULSE_CYC     = 12;
    localparam int c_HOLD_CYC      = 2;
    localparam int c_WAIT_CYC      = 2000;
    localparam int c_LONG_WAIT_CYC = 82000;

    localparam logic c_RS_CMD  = 1'b0;
    localparam logic c_RS_DATA = 1'b1;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle
    // time; every other command and all data writes use the normal one.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data_byte);
        return (rs == c_RS_CMD) && (data_byte[7:2] == 6'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_arbiter_if
//  Description : Requester handshake plus LCD pin bundle for lcd_bus_arbiter.
//  Signals     : Req[1:0], Rs_in[1:0], Data_in[15:0]  (requesters -> arbiter)
//                Ack[1:0], Busy                       (arbiter -> requesters)
//                LCD_E, LCD_RS, LCD_RW, LCD_Data[7:0] (arbiter -> LCD pins)
//  Modports    : master (requester/pin side), slave (arbiter side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcd_bus_arbiter_if;

    logic [1:0]  Req;
    logic [1:0]  Rs_in;
    logic [15:0] Data_in;
    logic [1:0]  Ack;
    logic        Busy;
    logic        LCD_E;
    logic        LCD_RS;
    logic        LCD_RW;
    logic [7:0]  LCD_Data;

    modport master (
        output Req, Rs_in, Data_in,
        input  Ack, Busy, LCD_E, LCD_RS, LCD_RW, LCD_Data
    );

    modport slave (
        input  Req, Rs_in, Data_in,
        output Ack, Busy, LCD_E, LCD_RS, LCD_RW, LCD_Data
    );

endinterface
`default_nettype wire

// File: rtl/lcd_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_rr_arbiter
//  Description : Two-way grant logic for the LCD bus. Round-robin with a Last
//                pointer by default; fixed priority (requester 0 wins) when
//                LCD_ARB_PRIORITY_EN is defined.
//  Ports       : Clock, Reset (async, active-low)
//                Req_i[1:0]   - request vector
//                Update_i     - a grant is being taken this cycle
//                Grant_o[1:0] - one-hot grant (combinational)
//  Macro       : LCD_ARB_PRIORITY_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_rr_arbiter (
    input  wire logic       Clock,
    input  wire logic       Reset,
    input  wire logic [1:0] Req_i,
    input  wire logic       Update_i,
    output logic      [1:0] Grant_o
);

`ifdef LCD_ARB_PRIORITY_EN

    // No history is kept in this variant, so the clock, reset and update
    // strobe are intentionally left dangling.
    logic w_unused;
    assign w_unused = ^{Clock, Reset, Update_i};

    always_comb begin
        Grant_o = 2'b00;
        if (Req_i[0]) begin
            Grant_o = 2'b01;
        end else if (Req_i[1]) begin
            Grant_o = 2'b10;
        end
    end

`else

    // Index of the requester granted most recently. Starts at 1 so that
    // requester 0 wins the first tie after reset.
    logic last_q;

    always_comb begin
        Grant_o = 2'b00;
        case (Req_i)
            2'b01:   Grant_o = 2'b01;
            2'b10:   Grant_o = 2'b10;
            2'b11:   Grant_o = last_q ? 2'b01 : 2'b10;
            default: Grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_q <= 1'b1;
        end else if (Update_i) begin
            last_q <= Grant_o[1];
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_bus_arbiter
//  Description : Shares the 8-bit HD44780 LCD bus between the init/command
//                controller (requester 0) and the text writer (requester 1).
//                Each grant runs SETUP -> E pulse -> HOLD -> settle WAIT and
//                finishes with a one-cycle Ack to the owner.
//  Ports       : Clock           - system clock
//                Reset           - asynchronous, active-low
//                bus (slave)     - Req/Rs_in/Data_in in, Ack/Busy and the
//                                  LCD_E/LCD_RS/LCD_RW/LCD_Data pins out
//  Parameters  : SETUP_CYC, PULSE_CYC, HOLD_CYC, WAIT_CYC, LONG_WAIT_CYC
//  Macro       : LCD_ARB_PRIORITY_EN selects fixed priority in lcd_rr_arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = c_SETUP_CYC,
    parameter int PULSE_CYC     = c_PULSE_CYC,
    parameter int HOLD_CYC      = c_HOLD_CYC,
    parameter int WAIT_CYC      = c_WAIT_CYC,
    parameter int LONG_WAIT_CYC = c_LONG_WAIT_CYC
) (
    input  wire logic         Clock,
    input  wire logic         Reset,
    lcd_bus_arbiter_if.slave  bus
);

    localparam int c_CNT_W = $clog2(LONG_WAIT_CYC + 1);
    typedef logic [c_CNT_W-1:0] cnt_t;

    localparam cnt_t c_SETUP_LD = cnt_t'(SETUP_CYC);
    localparam cnt_t c_PULSE_LD = cnt_t'(PULSE_CYC);
    localparam cnt_t c_HOLD_LD  = cnt_t'(HOLD_CYC);
    localparam cnt_t c_WAIT_LD  = cnt_t'(WAIT_CYC);
    localparam cnt_t c_LONG_LD  = cnt_t'(LONG_WAIT_CYC);
    localparam cnt_t c_CNT_ONE  = cnt_t'(1);

    lcd_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       e_q;
    logic       busy_q;
    logic [1:0] ack_q;

    logic [1:0] w_grant;
    logic       w_update;
    logic       w_sel_rs;
    logic [7:0] w_sel_data;
    logic       w_cnt_last;

    assign w_update   = (state_q == ST_IDLE) && (|bus.Req);
    assign w_sel_rs   = w_grant[1] ? bus.Rs_in[1]      : bus.Rs_in[0];
    assign w_sel_data = w_grant[1] ? bus.Data_in[15:8] : bus.Data_in[7:0];
    assign w_cnt_last = (cnt_q == c_CNT_ONE);

    lcd_rr_arbiter u_arb (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req_i    (bus.Req),
        .Update_i (w_update),
        .Grant_o  (w_grant)
    );

    // Each non-idle state lasts exactly the count loaded on entry: the
    // counter runs N..1 and the state is left on the cycle it reads 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        rs_d    = rs_q;
        data_d  = data_q;
        if (state_q != ST_IDLE && !w_cnt_last) begin
            cnt_d = cnt_q - c_CNT_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (w_update) begin
                    state_d = ST_SETUP;
                    cnt_d   = c_SETUP_LD;
                    owner_d = w_grant[1];
                    rs_d    = w_sel_rs;
                    data_d  = w_sel_data;
                end
            end
            ST_SETUP: begin
                if (w_cnt_last) begin
                    state_d = ST_PULSE;
                    cnt_d   = c_PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (w_cnt_last) begin
                    state_d = ST_HOLD;
                    cnt_d   = c_HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (w_cnt_last) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? c_LONG_LD : c_WAIT_LD;
                end
            end
            ST_WAIT: begin
                if (w_cnt_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so that they line
    // up with the state they describe, with no input-to-output paths.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= (state_d == ST_PULSE);
            busy_q  <= (state_d != ST_IDLE);
            if (state_d == ST_WAIT && cnt_d == c_CNT_ONE) begin
                ack_q <= owner_d ? 2'b10 : 2'b01;
            end else begin
                ack_q <= 2'b00;
            end
        end
    end

    assign bus.Ack      = ack_q;
    assign bus.Busy     = busy_q;
    assign bus.LCD_E    = e_q;
    assign bus.LCD_RS   = rs_q;
    assign bus.LCD_RW   = 1'b0;
    assign bus.LCD_Data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_bus_arbiter
//  Description : Self-checking bench for lcd_bus_arbiter. A transaction-level
//                model (offset within the current transaction, arbitration
//                by requester history) predicts every output every cycle.
//  Macro       : LCD_ARB_PRIORITY_EN switches the model to fixed priority
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_arbiter;

    localparam int S  = 2;
    localparam int P  = 5;
    localparam int H  = 2;
    localparam int W  = 20;
    localparam int LW = 60;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(
        .SETUP_CYC     (S),
        .PULSE_CYC     (P),
        .HOLD_CYC      (H),
        .WAIT_CYC      (W),
        .LONG_WAIT_CYC (LW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [13:0] obs_vec;
    assign obs_vec = {bus.Ack, bus.Busy, bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_Data};

    // ---------------- reference model ----------------
    int          m_k;      // 0 = idle, 1..m_len = cycle within transaction
    int          m_len;
    int          m_last;
    int          m_who;
    logic        m_rs;
    logic [7:0]  m_data;
    logic [1:0]  x_ack;
    logic [13:0] x_vec;

    // requester-side stimulus state
    logic       r_act [2];
    logic       r_rs  [2];
    logic [7:0] r_byte[2];

    function automatic int txn_len(input logic rs, input logic [7:0] b);
        return S + P + H + ((rs == 1'b0 && b < 8'd4) ? LW : W);
    endfunction

    task automatic model_reset();
        m_k = 0; m_len = 0; m_last = 1; m_who = 0; m_rs = 1'b0; m_data = 8'h00;
        x_ack = 2'b00;
    endtask

    task automatic model_expect();
        logic xb, xe;
        xb = (m_k > 0);
        xe = (m_k > S) && (m_k <= S + P);
        x_ack = 2'b00;
        if (m_k > 0 && m_k == m_len) x_ack[m_who] = 1'b1;
        x_vec = {x_ack, xb, xe, m_rs, 1'b0, m_data};
    endtask

    task automatic model_advance();
        int who;
        if (m_k == 0) begin
            if (bus.Req != 2'b00) begin
`ifdef LCD_ARB_PRIORITY_EN
                who = bus.Req[0] ? 0 : 1;
`else
                if (bus.Req == 2'b11) who = (m_last == 1) ? 0 : 1;
                else                  who = bus.Req[1] ? 1 : 0;
`endif
                m_who  = who;
                m_last = who;
                m_rs   = bus.Rs_in[who];
                m_data = bus.Data_in[who*8 +: 8];
                m_len  = txn_len(m_rs, m_data);
                m_k    = 1;
            end
        end else if (m_k == m_len) begin
            m_k = 0;
        end else begin
            m_k = m_k + 1;
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 2; i++) begin
            bus.Req[i]            = r_act[i];
            bus.Rs_in[i]          = r_rs[i];
            bus.Data_in[i*8 +: 8] = r_byte[i];
        end
    endtask

    task automatic new_byte(input int i);
        if ($urandom_range(0, 3) == 0) begin
            r_rs[i]   = 1'b0;
            r_byte[i] = 8'($urandom_range(0, 3));
        end else begin
            r_rs[i]   = 1'($urandom_range(0, 1));
            r_byte[i] = 8'($urandom);
        end
    endtask

    // Leaves the bench at posedge+1 of a fresh cycle with the DUT idle.
    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            r_act[i] = 1'b0; r_rs[i] = 1'b0; r_byte[i] = 8'h00;
        end
        apply();
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        model_reset();
        @(posedge Clock); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            r_act[i] = 1'b0; r_rs[i] = 1'b1; r_byte[i] = 8'hFF;
        end
        apply();
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== 14'd0) begin
            n_fail++; $display("FAIL reset_in got=%h exp=%h", obs_vec, 14'd0);
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        n_cmp++;
        if (obs_vec !== 14'd0) begin
            n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs_vec, 14'd0);
        end
        Reset = 1'b1;
        model_reset();
        @(posedge Clock); #1;
    endtask

    task automatic test_single_data();
        int first_e = -1, e_cnt = 0, ack_off = -1, idle_off = -1;
        do_reset();
        r_act[1] = 1'b1; r_rs[1] = 1'b1; r_byte[1] = 8'h41;
        r_rs[0] = 1'($urandom); r_byte[0] = 8'($urandom);
        apply();
        for (int off = 0; off < 40; off++) begin
            if (off == 4) bus.Data_in[15:8] = 8'hBE;   // must be ignored after grant
            @(negedge Clock);
            model_expect();
            n_cmp++;
            if (obs_vec !== x_vec) begin
                n_fail++; $display("FAIL single_bus cyc=%0d got=%h exp=%h", cyc, obs_vec, x_vec);
            end
            if (bus.LCD_E === 1'b1) begin
                if (first_e < 0) first_e = off;
                e_cnt++;
            end
            if (bus.Ack[1] === 1'b1) ack_off = off;
            if (ack_off >= 0 && idle_off < 0 && off > ack_off && bus.Busy === 1'b0) idle_off = off;
            model_advance();
            @(posedge Clock); #1;
            if (x_ack[1]) begin r_act[1] = 1'b0; apply(); end
        end
        n_cmp++;
        if (first_e !== S + 1) begin n_fail++; $display("FAIL single_e_start got=%0d exp=%0d", first_e, S + 1); end
        n_cmp++;
        if (e_cnt !== P) begin n_fail++; $display("FAIL single_e_len got=%0d exp=%0d", e_cnt, P); end
        n_cmp++;
        if (ack_off !== S + P + H + W) begin n_fail++; $display("FAIL single_ack got=%0d exp=%0d", ack_off, S + P + H + W); end
        n_cmp++;
        if (idle_off !== S + P + H + W + 1) begin n_fail++; $display("FAIL single_idle got=%0d exp=%0d", idle_off, S + P + H + W + 1); end
    endtask

    task automatic test_long_cmd();
        int ack_off = -1;
        do_reset();
        r_act[0] = 1'b1; r_rs[0] = 1'b0; r_byte[0] = 8'h01;
        apply();
        for (int off = 0; off < S + P + H + LW + 4; off++) begin
            @(negedge Clock);
            model_expect();
            n_cmp++;
            if (obs_vec !== x_vec) begin
                n_fail++; $display("FAIL long_bus cyc=%0d got=%h exp=%h", cyc, obs_vec, x_vec);
            end
            if (bus.Ack[0] === 1'b1) ack_off = off;
            model_advance();
            @(posedge Clock); #1;
            if (x_ack[0]) begin r_act[0] = 1'b0; apply(); end
        end
        n_cmp++;
        if (ack_off !== S + P + H + LW) begin n_fail++; $display("FAIL long_ack got=%0d exp=%0d", ack_off, S + P + H + LW); end
    endtask

    task automatic test_round_robin();
        int n_ack = 0;
        int exp_owner;
        do_reset();
        r_act[0] = 1'b1; r_rs[0] = 1'b1; r_byte[0] = 8'h30;
        r_act[1] = 1'b1; r_rs[1] = 1'b1; r_byte[1] = 8'h60;
        apply();
        for (int c = 0; c < 4 * (S + P + H + W + 1) + 2; c++) begin
            @(negedge Clock);
            model_expect();
            n_cmp++;
            if (obs_vec !== x_vec) begin
                n_fail++; $display("FAIL rr_bus cyc=%0d got=%h exp=%h", cyc, obs_vec, x_vec);
            end
            if (bus.Ack !== 2'b00) begin
`ifdef LCD_ARB_PRIORITY_EN
                exp_owner = 0;
`else
                exp_owner = n_ack % 2;
`endif
                n_cmp++;
                if (bus.Ack !== (exp_owner == 1 ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL rr_owner cyc=%0d got=%b exp_owner=%0d", cyc, bus.Ack, exp_owner);
                end
                n_cmp++;
                if (bus.LCD_Data !== r_byte[exp_owner]) begin
                    n_fail++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", cyc, bus.LCD_Data, r_byte[exp_owner]);
                end
                n_ack++;
            end
            model_advance();
            @(posedge Clock); #1;
            for (int i = 0; i < 2; i++) if (x_ack[i]) r_byte[i] = r_byte[i] + 8'd1;
            apply();
        end
        n_cmp++;
        if (n_ack !== 4) begin n_fail++; $display("FAIL rr_count got=%0d exp=%0d", n_ack, 4); end
    endtask

    task automatic test_drop_req();
        int n_ack0 = 0;
        do_reset();
        r_act[0] = 1'b1; r_rs[0] = 1'b1; r_byte[0] = 8'($urandom);
        apply();
        for (int off = 0; off < S + P + H + W + 6; off++) begin
            if (off == S + 2) begin r_act[0] = 1'b0; apply(); end
            @(negedge Clock);
            model_expect();
            n_cmp++;
            if (obs_vec !== x_vec) begin
                n_fail++; $display("FAIL drop_bus cyc=%0d got=%h exp=%h", cyc, obs_vec, x_vec);
            end
            if (bus.Ack[0] === 1'b1) n_ack0++;
            model_advance();
            @(posedge Clock); #1;
        end
        n_cmp++;
        if (n_ack0 !== 1) begin n_fail++; $display("FAIL drop_ack got=%0d exp=%0d", n_ack0, 1); end
        n_cmp++;
        if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle got=%b exp=%b", bus.Busy, 1'b0); end
    endtask

    task automatic test_reset_mid();
        int n_ack0 = 0;
        do_reset();
        r_act[1] = 1'b1; r_rs[1] = 1'b1; r_byte[1] = 8'h5A;
        apply();
        for (int off = 0; off < S + 3; off++) begin
            @(negedge Clock);
            model_expect();
            n_cmp++;
            if (obs_vec !== x_vec) begin
                n_fail++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, x_vec);
            end
            model_advance();
            @(posedge Clock); #1;
        end
        // now inside the E pulse; drop reset asynchronously mid-cycle
        #2;
        Reset = 1'b0;
        r_act[1] = 1'b0; apply();
        #1;
        n_cmp++;
        if ({bus.LCD_E, bus.Busy, bus.Ack} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_async got=%b exp=%b", {bus.LCD_E, bus.Busy, bus.Ack}, 4'b0000);
        end
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        model_reset();
        @(posedge Clock); #1;
        r_act[0] = 1'b1; r_rs[0] = 1'b1; r_byte[0] = 8'($urandom);
        apply();
        for (int off = 0; off < S + P + H + W + 3; off++) begin
            @(negedge Clock);
            model_expect();
            n_cmp++;
            if (obs_vec !== x_vec) begin
                n_fail++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", cyc, obs_vec, x_vec);
            end
            if (bus.Ack[0] === 1'b1) n_ack0++;
            model_advance();
            @(posedge Clock); #1;
            if (x_ack[0]) begin r_act[0] = 1'b0; apply(); end
        end
        n_cmp++;
        if (n_ack0 !== 1) begin n_fail++; $display("FAIL rstmid_ack got=%0d exp=%0d", n_ack0, 1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (r_act[i] && x_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) new_byte(i);
                    else r_act[i] = 1'b0;
                end else if (!r_act[i] && $urandom_range(0, 3) == 0) begin
                    r_act[i] = 1'b1;
                    new_byte(i);
                end
            end
            apply();
            @(negedge Clock);
            model_expect();
            n_cmp++;
            if (obs_vec !== x_vec) begin
                n_fail++; $display("FAIL random_bus cyc=%0d got=%h exp=%h", cyc, obs_vec, x_vec);
            end
            model_advance();
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_data();
        test_long_cmd();
        test_round_robin();
        test_drop_req();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
